// File: rtl/ps2_seq_pkg.sv
// Shared types and constants for the PS/2 text sequencer slice.
// Latency: none (declarations only).
// Backpressure: none; the PS/2 byte stream cannot be stalled.
package ps2_seq_pkg;

    typedef enum logic [1:0] {
        PFX_IDLE    = 2'd0,
        PFX_EXT     = 2'd1,
        PFX_BRK     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } pfx_state_t;

    localparam logic [7:0] F0_PREFIX    = 8'hF0;
    localparam logic [7:0] E0_PREFIX    = 8'hE0;

    localparam logic [7:0] DEF_ENTER    = 8'h5A;
    localparam logic [7:0] DEF_BKSP     = 8'h66;
    localparam logic [7:0] DEF_ESC      = 8'h76;

    localparam logic [7:0] BLANK_CODE   = 8'h00;

endpackage

// File: rtl/ps2_break_decoder.sv
// Prefix FSM: turns raw scan-code bytes into non-extended release events.
// Latency: rel_valid/rel_code are combinational with the completing rx_valid byte.
// Backpressure: none; every rx_valid byte is consumed in its cycle.
module ps2_break_decoder
    import ps2_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rel_valid,
    output logic [7:0] rel_code
);

    pfx_state_t state_q, state_d;

    // Next prefix state; in a break state any byte (even F0/E0) is the released code
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            unique case (state_q)
                PFX_IDLE: begin
                    if (rx_data == F0_PREFIX)      state_d = PFX_BRK;
                    else if (rx_data == E0_PREFIX) state_d = PFX_EXT;
                    else                           state_d = PFX_IDLE;
                end
                PFX_EXT: begin
                    if (rx_data == F0_PREFIX) state_d = PFX_EXT_BRK;
                    else                      state_d = PFX_IDLE;
                end
                PFX_BRK:     state_d = PFX_IDLE;
                PFX_EXT_BRK: state_d = PFX_IDLE;
                default:     state_d = PFX_IDLE;
            endcase
        end
    end

    // State register; reset and the idle-timeout clear drop any partial prefix
    always_ff @(posedge clk) begin
        if (reset || clr) state_q <= PFX_IDLE;
        else              state_q <= state_d;
    end

    // Extended releases (EXT_BRK) are swallowed without an event
    assign rel_valid = rx_valid && (state_q == PFX_BRK);
    assign rel_code  = rx_data;

endmodule

// File: rtl/ps2_text_sequencer.sv
// 3-char shift-in text buffer fed by PS/2 releases, with backspace/escape/Enter-commit and go pulse.
// Latency: outputs update on the clock edge after the byte completing a release (1 cycle).
// Backpressure: none; a full buffer rejects the char and pulses overflow. Option: PS2_SEQ_IDLE_TIMEOUT_EN.
module ps2_text_sequencer
    import ps2_seq_pkg::*;
#(
    parameter logic [7:0] ENTER_CODE     = DEF_ENTER,
    parameter logic [7:0] BKSP_CODE      = DEF_BKSP,
    parameter logic [7:0] ESC_CODE       = DEF_ESC,
    parameter int         TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] code1,
    output logic [7:0] code2,
    output logic [7:0] code3,
    output logic [7:0] out_code1,
    output logic [7:0] out_code2,
    output logic [7:0] out_code3,
    output logic [1:0] count,
    output logic       go,
    output logic       key_released,
    output logic       overflow
);

    logic       rel_valid;
    logic [7:0] rel_code;
    logic       fsm_clr;

    logic [7:0] code1_q, code1_d, code2_q, code2_d, code3_q, code3_d;
    logic [7:0] out_code1_q, out_code1_d, out_code2_q, out_code2_d, out_code3_q, out_code3_d;
    logic [1:0] count_q, count_d;
    logic       go_q, go_d, key_released_q, key_released_d, overflow_q, overflow_d;

    ps2_break_decoder u_break_decoder (
        .clk       (CLOCK_50),
        .reset     (reset),
        .clr       (fsm_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rel_valid (rel_valid),
        .rel_code  (rel_code)
    );

`ifdef PS2_SEQ_IDLE_TIMEOUT_EN
    localparam logic [27:0] TIMEOUT_LAST = 28'(TIMEOUT_CYCLES - 1);

    logic [27:0] idle_cnt_q, idle_cnt_d;
    logic        expire;

    // Idle counter: reloads on any byte, saturates at the last idle cycle so it never wraps
    always_comb begin
        expire     = !rx_valid && (idle_cnt_q == TIMEOUT_LAST);
        idle_cnt_d = idle_cnt_q;
        if (rx_valid)     idle_cnt_d = '0;
        else if (!expire) idle_cnt_d = idle_cnt_q + 28'd1;
    end

    // Idle counter register
    always_ff @(posedge CLOCK_50) begin
        if (reset) idle_cnt_q <= '0;
        else       idle_cnt_q <= idle_cnt_d;
    end

    // Expiry with a partial entry wipes it; with an empty buffer it does nothing
    assign fsm_clr = expire && (count_q != 2'd0);
`else
    assign fsm_clr = 1'b0;
`endif

    // Buffer, commit and pulse next-state logic driven by release events
    always_comb begin
        code1_d        = code1_q;
        code2_d        = code2_q;
        code3_d        = code3_q;
        out_code1_d    = out_code1_q;
        out_code2_d    = out_code2_q;
        out_code3_d    = out_code3_q;
        count_d        = count_q;
        go_d           = 1'b0;
        key_released_d = 1'b0;
        overflow_d     = 1'b0;

        if (rel_valid) begin
            key_released_d = 1'b1;
            if (rel_code == ENTER_CODE) begin
                if (count_q != 2'd0) begin
                    out_code1_d = code1_q;
                    out_code2_d = code2_q;
                    out_code3_d = code3_q;
                    go_d        = 1'b1;
                    code1_d     = BLANK_CODE;
                    code2_d     = BLANK_CODE;
                    code3_d     = BLANK_CODE;
                    count_d     = 2'd0;
                end
            end else if (rel_code == BKSP_CODE) begin
                if (count_q != 2'd0) begin
                    code1_d = code2_q;
                    code2_d = code3_q;
                    code3_d = BLANK_CODE;
                    count_d = count_q - 2'd1;
                end
            end else if (rel_code == ESC_CODE) begin
                code1_d = BLANK_CODE;
                code2_d = BLANK_CODE;
                code3_d = BLANK_CODE;
                count_d = 2'd0;
            end else if (count_q != 2'd3) begin
                code3_d = code2_q;
                code2_d = code1_q;
                code1_d = rel_code;
                count_d = count_q + 2'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (fsm_clr) begin
            code1_d = BLANK_CODE;
            code2_d = BLANK_CODE;
            code3_d = BLANK_CODE;
            count_d = 2'd0;
        end
    end

    // Output registers; reset clears everything including committed codes
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            code1_q        <= BLANK_CODE;
            code2_q        <= BLANK_CODE;
            code3_q        <= BLANK_CODE;
            out_code1_q    <= BLANK_CODE;
            out_code2_q    <= BLANK_CODE;
            out_code3_q    <= BLANK_CODE;
            count_q        <= 2'd0;
            go_q           <= 1'b0;
            key_released_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            code1_q        <= code1_d;
            code2_q        <= code2_d;
            code3_q        <= code3_d;
            out_code1_q    <= out_code1_d;
            out_code2_q    <= out_code2_d;
            out_code3_q    <= out_code3_d;
            count_q        <= count_d;
            go_q           <= go_d;
            key_released_q <= key_released_d;
            overflow_q     <= overflow_d;
        end
    end

    assign code1        = code1_q;
    assign code2        = code2_q;
    assign code3        = code3_q;
    assign out_code1    = out_code1_q;
    assign out_code2    = out_code2_q;
    assign out_code3    = out_code3_q;
    assign count        = count_q;
    assign go           = go_q;
    assign key_released = key_released_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_text_sequencer.sv
// Directed bench for ps2_text_sequencer; optional section exercises PS2_SEQ_IDLE_TIMEOUT_EN.
// Latency: checks outputs one clock after the completing byte.
// Backpressure: n/a (the DUT never stalls the byte stream).
module tb_ps2_text_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] code1, code2, code3, out_code1, out_code2, out_code3;
    logic [1:0] count;
    logic       go, key_released, overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_text_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .code1        (code1),
        .code2        (code2),
        .code3        (code3),
        .out_code1    (out_code1),
        .out_code2    (out_code2),
        .out_code3    (out_code3),
        .count        (count),
        .go           (go),
        .key_released (key_released),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the byte captured
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
    endtask

    task automatic release_key(input logic [7:0] b);
        send_byte(8'hF0);
        send_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_code1", 32'(code1), 0);
        check("rst_out1",  32'(out_code1), 0);
        check("rst_pulses", {29'd0, go, key_released, overflow}, 0);

        // make code alone is ignored
        send_byte(8'h1C);
        check("make_count", 32'(count), 0);
        check("make_krel",  32'(key_released), 0);
        send_byte(8'hF0);
        check("f0_krel", 32'(key_released), 0);
        send_byte(8'h1C);
        check("rel_krel",  32'(key_released), 1);
        check("rel_code1", 32'(code1), 32'h1C);
        check("rel_count", 32'(count), 1);
        idle(1);
        check("krel_1cyc", 32'(key_released), 0);
        send_byte(8'h1C);
        check("typematic_count", 32'(count), 1);

        // fill and commit
        release_key(8'h32);
        release_key(8'h21);
        check("fill_c3", 32'(code3), 32'h1C);
        check("fill_c2", 32'(code2), 32'h32);
        check("fill_c1", 32'(code1), 32'h21);
        release_key(8'h5A);
        check("go_pulse", 32'(go), 1);
        check("commit_o3", 32'(out_code3), 32'h1C);
        check("commit_o2", 32'(out_code2), 32'h32);
        check("commit_o1", 32'(out_code1), 32'h21);
        check("commit_cnt", 32'(count), 0);
        check("commit_c1", 32'(code1), 0);
        idle(1);
        check("go_1cyc", 32'(go), 0);

        // overflow
        release_key(8'h1C);
        release_key(8'h32);
        release_key(8'h21);
        release_key(8'h24);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_krel",  32'(key_released), 1);
        check("ovf_count", 32'(count), 3);
        check("ovf_c1",    32'(code1), 32'h21);
        check("ovf_c3",    32'(code3), 32'h1C);
        idle(1);
        check("ovf_1cyc", 32'(overflow), 0);
        release_key(8'h76);
        check("esc_count", 32'(count), 0);
        check("esc_keep_out", 32'(out_code1), 32'h21);

        // backspace, escape, empty enter
        release_key(8'h1C);
        release_key(8'h32);
        release_key(8'h66);
        check("bksp_c1", 32'(code1), 32'h1C);
        check("bksp_c2", 32'(code2), 0);
        check("bksp_cnt", 32'(count), 1);
        release_key(8'h76);
        check("esc_c1", 32'(code1), 0);
        check("esc_cnt", 32'(count), 0);
        release_key(8'h5A);
        check("empty_enter_go", 32'(go), 0);
        check("empty_enter_krel", 32'(key_released), 1);
        check("empty_enter_out", 32'(out_code2), 32'h32);
        release_key(8'h66);
        check("bksp_empty_cnt", 32'(count), 0);

        // extended release ignored; F0 after F0 is a code
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("ext_krel", 32'(key_released), 0);
        check("ext_cnt", 32'(count), 0);
        release_key(8'h44);
        check("after_ext_c1", 32'(code1), 32'h44);
        release_key(8'hF0);
        check("f0f0_c1", 32'(code1), 32'hF0);
        check("f0f0_cnt", 32'(count), 2);
        release_key(8'h76);

        // reset between F0 and 44 drops the prefix and the committed codes
        send_byte(8'hF0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send_byte(8'h44);
        check("rst_mid_krel", 32'(key_released), 0);
        check("rst_mid_cnt", 32'(count), 0);
        check("rst_mid_out", 32'(out_code1), 0);

        // reset dominates a completing byte in the same cycle
        send_byte(8'hF0);
        reset    = 1'b1;
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        idle(1);
        reset    = 1'b0;
        rx_valid = 1'b0;
        check("rst_dom_krel", 32'(key_released), 0);
        check("rst_dom_cnt", 32'(count), 0);

`ifdef PS2_SEQ_IDLE_TIMEOUT_EN
        release_key(8'h1C);
        idle(99);
        check("to_before", 32'(count), 1);
        idle(1);
        check("to_cleared", 32'(count), 0);
        check("to_no_go", 32'(go), 0);
        release_key(8'h1C);
        idle(99);
        send_byte(8'h1C);
        check("to_byte_wins", 32'(count), 1);
        idle(50);
        check("to_reloaded", 32'(count), 1);
`else
        release_key(8'h1C);
        idle(300);
        check("hold_idle", 32'(count), 1);
        check("hold_c1", 32'(code1), 32'h1C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
